pmod_button_conditioner: RTL
============================

// Module: pmod_button_conditioner
// PURPOSE
//  Input-side conditioner for the active-low PMOD push-buttons.
//  - Synchronises, debounces and inverts each raw pin.
//  - Outputs clean active-high levels plus one-cycle press/release pulses.
//  - Sits between the board pins and the combinational button->LED logic, which then
//    consumes active-high, glitch-free levels instead of raw pins.
// PARAMETERS
//  N_BTN            3       number of button channels
//  DEBOUNCE_CYCLES  120000  stable cycles to accept a change (10 ms @ 12 MHz); must be >= 2
//  REPEAT_DELAY     6000000 hold cycles before first auto-repeat pulse (BTN_REPEAT_EN only)
//  REPEAT_PERIOD    1200000 cycles between subsequent auto-repeat pulses (BTN_REPEAT_EN only)
// PORTS
//  clk          in   1      system clock, single clock domain
//  rst_n        in   1      asynchronous active-low reset
//  pmod         in   N_BTN  raw button pins; 0 = pressed; asynchronous to clk
//  btn_level    out  N_BTN  debounced level; 1 = pressed
//  btn_press    out  N_BTN  1-cycle pulse on accepted press (and on auto-repeat if enabled)
//  btn_release  out  N_BTN  1-cycle pulse on accepted release
// BEHAVIOUR
//  - Reset (rst_n low, async assert):
//    - sync flops = 1; btn_level, btn_press, btn_release = 0.
//    - all FSMs RELEASED; all counters 0.
//    - Reset mid-debounce or mid-hold discards the channel's state; no pulse is emitted.
//  - Synchroniser: 2 flops per channel; s = ~sync2 (active-high synced sample).
//  - Per-channel FSM (all channels are independent):
//    - RELEASED: s=1 -> PRESS_WAIT, cnt=1.
//    - PRESS_WAIT:
//      - s=0 -> RELEASED, cnt=0 (bounce rejected, no pulse).
//      - s=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED; btn_level<=1; btn_press<=1 for 1 cycle.
//      - else cnt++.
//    - PRESSED: s=0 -> RELEASE_WAIT, cnt=1.
//    - RELEASE_WAIT: mirror of PRESS_WAIT.
//      - s=1 -> PRESSED (no pulse).
//      - s=0 and cnt==DEBOUNCE_CYCLES-1 -> RELEASED; btn_level<=0; btn_release<=1.
//  - Latency:
//    - pin edge to s: 2 cycles.
//    - s steady to btn_level change: DEBOUNCE_CYCLES cycles.
//    - btn_press/btn_release assert in the same cycle btn_level changes.
//  - cnt width: $clog2(DEBOUNCE_CYCLES); cnt never wraps, always cleared on state change.
//  - btn_press and btn_release are never both high on the same channel in the same cycle.
//  - Simultaneous presses on different channels each produce their own pulse, same cycle.
//  - DEBOUNCE_CYCLES < 2: elaboration-time error.
// CONFIGURATION
//  BTN_REPEAT_EN defined:
//    - In PRESSED, a hold counter runs.
//    - Extra btn_press pulse REPEAT_DELAY cycles after entry, then every REPEAT_PERIOD cycles.
//    - Hold counter clears on leaving PRESSED.
//    - RELEASE_WAIT freezes the hold counter; return to PRESSED resumes from the frozen value.
//  BTN_REPEAT_EN undefined: no hold counter logic; exactly one btn_press per accepted press.
// STRUCTURE
//  - Package pmod_io_pkg:
//    - btn_state_t enum {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT}.
//    - SYNC_STAGES=2.
//  - Sub-module btn_debounce_ch:
//    - One channel: sync, FSM, counters.
//    - Instantiated N_BTN times via generate.
//  - Top level contains only the generate loop and port wiring.
// TESTING (sim with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
//  1 Reset: rst_n=0 with pmod=000 -> all outputs 0; release reset -> press pulses occur only
//    after 2+4 cycles.
//  2 Clean press: pmod[0] 1->0 held -> btn_level[0]=1 and btn_press[0]=1 for 1 cycle, exactly
//    6 cycles after the edge.
//  3 Bounce: pmod[1] low 3 cycles then high -> no level change, no pulse; low 4+ cycles ->
//    accepted press.
//  4 Release: from pressed, pmod[0] 0->1 -> btn_level[0]=0 and btn_release[0] pulse after
//    6 cycles; 2-cycle glitch back low is ignored.
//  5 Parallel: pmod 111->000 same cycle -> btn_press=111 in one cycle, btn_level=111.
//  6 Repeat (BTN_REPEAT_EN): hold 30 cycles -> press pulses at acceptance, +10, +13, +16...;
//    without the macro -> single pulse; assert rst_n mid-hold -> no further pulses.

Source files
------------

// File: rtl/pmod_io_pkg.sv
// Shared types and constants for the PMOD button input path.
package pmod_io_pkg;

    localparam int unsigned SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM, press/release pulses.
// Optional auto-repeat of btn_press while held is enabled with `define BTN_REPEAT_EN.
module btn_debounce_ch
    import pmod_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned REPEAT_DELAY    = 6000000,
    parameter int unsigned REPEAT_PERIOD   = 1200000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("btn_debounce_ch: DEBOUNCE_CYCLES must be >= 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("btn_debounce_ch: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

`ifdef BTN_REPEAT_EN
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] HOLD_DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] HOLD_PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

    logic [HOLD_W-1:0] hold_q;
    logic              rep_q;
`endif

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    btn_state_t             state_q;
    logic [CNT_W-1:0]       cnt_q;

    // Pin is active-low and asynchronous; idle (released) level is 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
        end
    end

    assign s = ~sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RELEASED;
            cnt_q         <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
`ifdef BTN_REPEAT_EN
            hold_q        <= '0;
            rep_q         <= 1'b0;
`endif
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state_q)
                RELEASED: begin
                    if (s) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state_q <= RELEASED;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q     <= PRESSED;
                        cnt_q       <= '0;
                        level       <= 1'b1;
                        press_pulse <= 1'b1;
`ifdef BTN_REPEAT_EN
                        hold_q      <= '0;
                        rep_q       <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= CNT_W'(1);
                    end
`ifdef BTN_REPEAT_EN
                    // First repeat after REPEAT_DELAY, then every REPEAT_PERIOD.
                    else if (hold_q == (rep_q ? HOLD_PERIOD_LAST : HOLD_DELAY_LAST)) begin
                        press_pulse <= 1'b1;
                        hold_q      <= '0;
                        rep_q       <= 1'b1;
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
`endif
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q       <= RELEASED;
                        cnt_q         <= '0;
                        level         <= 1'b0;
                        release_pulse <= 1'b1;
`ifdef BTN_REPEAT_EN
                        hold_q        <= '0;
                        rep_q         <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= RELEASED;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pmod_button_conditioner.sv
// Conditions N_BTN active-low PMOD buttons into clean active-high levels and pulses.
// Define BTN_REPEAT_EN to enable auto-repeat press pulses while a button is held.
module pmod_button_conditioner
    import pmod_io_pkg::*;
#(
    parameter int unsigned N_BTN           = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned REPEAT_DELAY    = 6000000,
    parameter int unsigned REPEAT_PERIOD   = 1200000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] pmod,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    for (genvar i = 0; i < int'(N_BTN); i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .pin           (pmod[i]),
            .level         (btn_level[i]),
            .press_pulse   (btn_press[i]),
            .release_pulse (btn_release[i])
        );
    end

endmodule
